seq_detect_ctrl: RTL



---
 rtl/seq_ctrl_pkg.sv | 13 +
 rtl/seq_match_core.sv | 70 +++++++
 rtl/seq_detect_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared constants for the serial pattern detector.
// State encodings and configuration reset defaults.
package seq_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] SHIFT = 2'd1;

  localparam logic [4:0] SEQ_DEFAULT_PATTERN = 5'b10101;
  localparam int         SEQ_DEFAULT_THRESH  = 1;

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, fill counter and registered match.
// SEQ_CTRL_NONOVERLAP_EN clears the history on every match.
module seq_match_core #(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             match
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic [PAT_W-1:0] shifted;
  logic [FW-1:0]    fill_inc;

  // Candidate history and the same-edge hit it would produce
  always_comb begin
    shifted  = {hist_q[PAT_W-2:0], bit_in};
    fill_inc = (fill_q >= FW'(PAT_W))
             ? fill_q : fill_q + 1'b1;
    hit      = bit_vld
            && (shifted == pattern)
            && (fill_inc >= FW'(PAT_W));
  end

  // History update; hit is registered into a one-cycle pulse
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_vld) begin
      hist_d  = shifted;
      fill_d  = fill_inc;
      match_d = hit;
`ifdef SEQ_CTRL_NONOVERLAP_EN
      if (hit) begin
        hist_d = '0;
        fill_d = '0;
      end
`endif
    end
  end

  // History and match registers
  always_ff @(posedge clk) begin
    if (clr) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word serializer, match counter and sticky irq.
// Optional: SEQ_CTRL_NONOVERLAP_EN selects non-overlapping matches.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               irq_ack,
  output logic               bit_out,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  output logic               busy,
  output logic [STATE_W-1:0] state
);

  localparam int IW = $clog2(WORD_W);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic               is_idle, is_shift;
  logic               accept, flush, hit;
  logic [CNT_W-1:0]   cnt_inc;

  assign is_idle  = (state_q == IDLE);
  assign is_shift = (state_q == SHIFT);
  assign accept   = in_valid && is_idle;
  assign flush    = cfg_we && is_idle;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; illegal encodings fall back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? SHIFT : IDLE;
      SHIFT:   state_d = (idx_q == '0) ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    in_ready  = is_idle;
    busy      = is_shift;
    bit_out   = is_shift & word_q[idx_q];
    state     = state_q;
    match_cnt = cnt_q;
    irq       = irq_q;
  end

  // Word capture and MSB-first bit index
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (accept) begin
      word_d = in_data;
      idx_d  = IW'(WORD_W - 1);
    end else if (is_shift) begin
      idx_d = idx_q - 1'b1;
    end
  end

  // Config load, saturating count and sticky irq
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    pat_d   = pat_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    if (flush) begin
      pat_d = cfg_pattern;
      thr_d = cfg_thresh;
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (hit) cnt_d = cnt_inc;
      if (hit && (thr_q != '0)
          && (cnt_inc == thr_q))
        irq_d = 1'b1;
      else if (irq_ack)
        irq_d = 1'b0;
    end
  end

  // Datapath and configuration registers
  always_ff @(posedge clk) begin
    if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
      pat_q  <= PAT_W'(SEQ_DEFAULT_PATTERN);
      thr_q  <= CNT_W'(SEQ_DEFAULT_THRESH);
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      pat_q  <= pat_d;
      thr_q  <= thr_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk     (clk),
    .clr     (clr),
    .flush   (flush),
    .bit_vld (is_shift),
    .bit_in  (bit_out),
    .pattern (pat_q),
    .hit     (hit),
    .match   (match)
  );

endmodule
